mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter for the Von Neumann datapath: instruction fetch and load/store share one synchronous 16-bit memory, and this block sits directly upstream of `memory`, owning its `enable`/`writeEnable`/`address`/`writeData` inputs and routing `readData` back. It serialises one access at a time through a 4-state FSM. Data accesses get priority, with a streak limit so fetch is never starved.

## Interface
- `ADDR_W`, 16, address width, matches `memory.address`
- `DATA_W`, 16, word width, matches `memory.writeData`/`readData`
- `MAX_DATA_STREAK`, 4, max consecutive data grants while fetch is waiting
- `clock` in 1: sole clock, rising edge
- `resetN` in 1: asynchronous, active-low reset
- `fetchReq` in 1: fetch request, held until `fetchGnt`
- `fetchAddr` in ADDR_W: fetch word address
- `fetchGnt` out 1: one-cycle grant pulse
- `fetchValid` out 1: one-cycle pulse, `fetchData` valid
- `fetchData` out DATA_W: instruction word
- `dataReq` in 1: load/store request, held until `dataGnt`
- `dataWe` in 1: 1 = store, 0 = load
- `dataAddr` in ADDR_W: load/store address
- `dataWData` in DATA_W: store data
- `dataGnt` out 1: one-cycle grant pulse
- `dataValid` out 1: one-cycle pulse, load data valid or store acknowledge
- `dataRData` out DATA_W: load data; 0 on store ack
- `memEnable`, `memWriteEnable` out 1: to `memory.enable`/`writeEnable`
- `memAddress` out ADDR_W, `memWriteData` out DATA_W: to memory
- `memReadData` in DATA_W: from `memory.readData`
- `busy` out 1: high in any state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- Arbitration happens in IDLE and RESP.
  - If no request is pending, stay in (or go to) IDLE.
  - Otherwise pick a winner, latch its addr/wdata/we and the port id, and go to ISSUE.
- Priority:
  - Data wins a simultaneous request.
  - Exception: fetch wins if `fetchReq`=1 and `streak`==MAX_DATA_STREAK.
- `streak` counter:
  - Increments on a data grant while `fetchReq`=1.
  - Clears on a fetch grant, or on any cycle with `fetchReq`=0.
  - Saturates at MAX_DATA_STREAK.
- ISSUE (1 cycle):
  - `memEnable`=1, plus `memWriteEnable`=latched we.
  - Gnt pulse to the winner.
  - Memory samples at the closing edge.
  - Next state WAIT.
- WAIT (1 cycle): `memReadData` is valid. Capture it (or 0 for a store) into the response register. Next state RESP.
- RESP (1 cycle): Valid pulse on the winner's port, with its data output driven from the response register. The data output holds that value until the next response. Arbitration proceeds in parallel.
- `memAddress`/`memWriteData` are registered. They update only on entry to ISSUE and hold between accesses.
- `memEnable`/`memWriteEnable` are 0 outside ISSUE.
- A requester dropping req before its gnt has no effect: the request is simply not granted.
- Reset mid-operation:
  - All outputs go to 0 immediately and state returns to IDLE; `streak` goes to 0.
  - The in-flight response is discarded and no valid is issued.
  - A store whose ISSUE edge already occurred stays committed in memory.

## Timing
- All outputs are registered; reset value of every output is 0.
- Request seen in IDLE in cycle N:
  - cycle N+1: gnt and mem controls high
  - cycle N+2: WAIT
  - cycle N+3: valid
- Back-to-back: a request pending in RESP (N+3) reaches ISSUE at N+4. Peak throughput is one access per 3 cycles.
- The gnt pulse and the mem strobes coincide exactly. Valid follows gnt by exactly 2 cycles.
- Address and data pass through unmodified; there is no width conversion.

## Structure
- Package `mem_arb_pkg`:
  - state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
  - port-id constants (PORT_FETCH=0, PORT_DATA=1)
  - default `ADDR_W`/`DATA_W`
- Sub-module `arb_streak_select`: combinational winner select plus the saturating `streak` counter, width `$clog2(MAX_DATA_STREAK+1)`.
- Top level holds the FSM, request latches, response register and memory-side registers.

## Test plan
- Reset, then a lone fetch of addr 0x0000 with mem[0]=0x1234 -> `fetchGnt` at N+1, `fetchValid` with `fetchData`=0x1234 at N+3, `memEnable` high exactly 1 cycle.
- Store 0xFA2D to 0x000F, then load 0x000F -> store ack with `dataRData`=0, `memWriteEnable` high 1 cycle; load returns 0xFA2D.
- `fetchReq` and `dataReq` asserted together and held -> data granted first, fetch granted next at RESP+1; grant spacing is 3 cycles.
- `dataReq` held continuously with `fetchReq` held, MAX_DATA_STREAK=4 -> grant order D,D,D,D,F,D,D,D,D,F.
- `resetN` pulled low during WAIT of a load -> outputs 0 asynchronously, no `dataValid`, `busy`=0, next request completes normally.
- Store 0x2231 to 0x0014 with reset asserted during RESP -> subsequent load of 0x0014 returns 0x2231.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W          = 16;
  localparam int unsigned DEF_DATA_W          = 16;
  localparam int unsigned DEF_MAX_DATA_STREAK = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } arb_port_e;

  // States in which a new winner may be picked.
  function automatic logic is_arb_state(input arb_state_e s);
    return (s == S_IDLE) || (s == S_RESP);
  endfunction

endpackage

// File: rtl/arb_streak_select.sv
// Winner select between fetch and data, with a saturating data-streak
// counter that forces a fetch grant once data has won too many times.
module arb_streak_select
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic fetch_req,
  input  logic data_req,
  output logic pick_fetch_c,
  output logic pick_data_c
);

  localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  logic [STREAK_W-1:0] streak_q;
  logic                fetch_due_c;

  // Data has priority unless fetch has waited through a full streak.
  always_comb begin
    fetch_due_c  = fetch_req && (streak_q == STREAK_MAX);
    pick_data_c  = arb_en && data_req && !fetch_due_c;
    pick_fetch_c = arb_en && fetch_req && !pick_data_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else if (!fetch_req || pick_fetch_c) begin
      streak_q <= '0;
    end else if (pick_data_c && (streak_q != STREAK_MAX)) begin
      streak_q <= streak_q + STREAK_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction fetch and load/store onto one synchronous memory,
// one access at a time: ISSUE drives the strobes, WAIT captures, RESP replies.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W          = DEF_ADDR_W,
  parameter int unsigned DATA_W          = DEF_DATA_W,
  parameter int unsigned MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              fetchReq,
  input  logic [ADDR_W-1:0] fetchAddr,
  output logic              fetchGnt,
  output logic              fetchValid,
  output logic [DATA_W-1:0] fetchData,
  input  logic              dataReq,
  input  logic              dataWe,
  input  logic [ADDR_W-1:0] dataAddr,
  input  logic [DATA_W-1:0] dataWData,
  output logic              dataGnt,
  output logic              dataValid,
  output logic [DATA_W-1:0] dataRData,
  output logic              memEnable,
  output logic              memWriteEnable,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWriteData,
  input  logic [DATA_W-1:0] memReadData,
  output logic              busy
);

  arb_state_e state_q, state_d;
  arb_port_e  port_q, port_d;
  logic       we_q, we_d;

  logic arb_en_c;
  logic pick_fetch_c, pick_data_c;

  logic              fetch_gnt_d, data_gnt_d;
  logic              fetch_valid_d, data_valid_d;
  logic              mem_en_d, mem_we_d, busy_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, fetch_data_d, data_rdata_d;

  assign arb_en_c = is_arb_state(state_q);

  arb_streak_select #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_select (
    .clk         (clock),
    .rst_n       (resetN),
    .arb_en      (arb_en_c),
    .fetch_req   (fetchReq),
    .data_req    (dataReq),
    .pick_fetch_c(pick_fetch_c),
    .pick_data_c (pick_data_c)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE,
      S_RESP:  state_d = (pick_fetch_c || pick_data_c) ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of every registered output; memory-side regs hold by default.
  always_comb begin
    port_d        = port_q;
    we_d          = we_q;
    fetch_gnt_d   = 1'b0;
    data_gnt_d    = 1'b0;
    fetch_valid_d = 1'b0;
    data_valid_d  = 1'b0;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = memAddress;
    mem_wdata_d   = memWriteData;
    fetch_data_d  = fetchData;
    data_rdata_d  = dataRData;
    busy_d        = (state_d != S_IDLE);

    if (pick_data_c) begin
      port_d      = PORT_DATA;
      we_d        = dataWe;
      mem_addr_d  = dataAddr;
      mem_wdata_d = dataWData;
      data_gnt_d  = 1'b1;
      mem_en_d    = 1'b1;
      mem_we_d    = dataWe;
    end else if (pick_fetch_c) begin
      port_d      = PORT_FETCH;
      we_d        = 1'b0;
      mem_addr_d  = fetchAddr;
      mem_wdata_d = '0;
      fetch_gnt_d = 1'b1;
      mem_en_d    = 1'b1;
    end

    // Read data is valid in WAIT; the output data regs act as response regs.
    if (state_q == S_WAIT) begin
      if (port_q == PORT_DATA) begin
        data_valid_d = 1'b1;
        data_rdata_d = we_q ? '0 : memReadData;
      end else begin
        fetch_valid_d = 1'b1;
        fetch_data_d  = memReadData;
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      port_q         <= PORT_FETCH;
      we_q           <= 1'b0;
      fetchGnt       <= 1'b0;
      dataGnt        <= 1'b0;
      fetchValid     <= 1'b0;
      dataValid      <= 1'b0;
      memEnable      <= 1'b0;
      memWriteEnable <= 1'b0;
      memAddress     <= '0;
      memWriteData   <= '0;
      fetchData      <= '0;
      dataRData      <= '0;
      busy           <= 1'b0;
    end else begin
      port_q         <= port_d;
      we_q           <= we_d;
      fetchGnt       <= fetch_gnt_d;
      dataGnt        <= data_gnt_d;
      fetchValid     <= fetch_valid_d;
      dataValid      <= data_valid_d;
      memEnable      <= mem_en_d;
      memWriteEnable <= mem_we_d;
      memAddress     <= mem_addr_d;
      memWriteData   <= mem_wdata_d;
      fetchData      <= fetch_data_d;
      dataRData      <= data_rdata_d;
      busy           <= busy_d;
    end
  end

endmodule
